// File: rtl/cpu_pkg.sv
// Shared widths, fill word and state encodings for the instruction store.
package cpu_pkg;
    localparam int INSTR_W = 16;
    localparam int IDX_W = 8;
    localparam logic [INSTR_W-1:0] FILL_WORD = 16'hfee7;

    typedef enum logic [1:0] {EMPTY, LOADING, READY} store_state_t;

    // Source of fetch_data in the cycle after a fetch request.
    typedef enum logic [1:0] {DATA_HOLD, DATA_RAM, DATA_FILL, DATA_ZERO} data_sel_t;

    function automatic logic idx_in_range(input logic [IDX_W-1:0] idx, input int depth);
        return int'(idx) < depth;
    endfunction
endpackage

// File: rtl/instr_ram.sv
// Simple dual-port instruction RAM: one write port, one registered read port, no reset.
module instr_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 16,
    parameter int AW = 8
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/instruction_store.sv
// Program store filled by a loader while the CPU is held, then serving 1-cycle fetches
// with a per-slot written map that flags fetches of unwritten slots.
module instruction_store
    import cpu_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter logic [15:0] FILL_WORD = cpu_pkg::FILL_WORD
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_active,
    input  logic         write_en,
    input  logic [7:0]   write_index,
    input  logic [15:0]  write_instruction,
    input  logic [7:0]   fetch_addr,
    input  logic         fetch_en,
    output logic [15:0]  fetch_data,
    output logic         fetch_valid,
    output logic         fetch_fault,
    output logic         ready,
    output logic [7:0]   loaded_count,
    output logic [15:0]  checksum
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    store_state_t        state_reg;
    data_sel_t           data_sel_reg;
    logic [INSTR_W-1:0]  hold_reg;
    logic [INSTR_W-1:0]  ram_data;
    logic [DEPTH-1:0]    written_reg;
    logic                valid_reg;
    logic                fault_reg;
    logic                ready_reg;
    logic [IDX_W-1:0]    count_reg;
    logic [INSTR_W-1:0]  sum_reg;

    logic accept;
    logic served;
    logic fault_now;

    assign accept    = (state_reg == LOADING) && write_en && idx_in_range(write_index, DEPTH);
    assign served    = fetch_en && (state_reg == READY);
    assign fault_now = !idx_in_range(fetch_addr, DEPTH) || !written_reg[fetch_addr[AW-1:0]];

    instr_ram #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (write_index[AW-1:0]),
        .wr_data (write_instruction),
        .rd_en   (served),
        .rd_addr (fetch_addr[AW-1:0]),
        .rd_data (ram_data)
    );

    always_comb begin
        fetch_data = hold_reg;
        case (data_sel_reg)
            DATA_RAM:  fetch_data = ram_data;
            DATA_FILL: fetch_data = FILL_WORD;
            DATA_ZERO: fetch_data = '0;
            default:   fetch_data = hold_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= EMPTY;
            data_sel_reg <= DATA_HOLD;
            hold_reg     <= '0;
            written_reg  <= '0;
            valid_reg    <= 1'b0;
            fault_reg    <= 1'b0;
            ready_reg    <= 1'b0;
            count_reg    <= '0;
            sum_reg      <= '0;
        end else begin
            // Fetch response path: an in-flight fetch completes even if a load starts.
            hold_reg  <= fetch_data;
            valid_reg <= served;
            fault_reg <= served && fault_now;
            if (!fetch_en) begin
                data_sel_reg <= DATA_HOLD;
            end else if (!served) begin
                data_sel_reg <= DATA_ZERO;
            end else if (fault_now) begin
                data_sel_reg <= DATA_FILL;
            end else begin
                data_sel_reg <= DATA_RAM;
            end

            case (state_reg)
                EMPTY, READY: begin
                    if (load_active) begin
                        state_reg   <= LOADING;
                        ready_reg   <= 1'b0;
                        count_reg   <= '0;
                        sum_reg     <= '0;
                        written_reg <= '0;
                    end
                end
                LOADING: begin
                    if (accept) begin
                        written_reg[write_index[AW-1:0]] <= 1'b1;
                        sum_reg <= sum_reg + write_instruction;
                        if (count_reg != 8'hff) begin
                            count_reg <= count_reg + 8'd1;
                        end
                    end
                    if (!load_active) begin
                        if ((count_reg != '0) || accept) begin
                            state_reg <= READY;
                            ready_reg <= 1'b1;
                        end else begin
                            state_reg <= EMPTY;
                            ready_reg <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg <= EMPTY;
                    ready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign fetch_valid  = valid_reg;
    assign fetch_fault  = fault_reg;
    assign ready        = ready_reg;
    assign loaded_count = count_reg;
    assign checksum     = sum_reg;
endmodule

// File: tb/tb_instruction_store.sv
// Scoreboard bench for instruction_store: fetch expectations are queued at issue time
// and checked by an independent monitor one cycle later.
module tb_instruction_store;
    logic        clk = 1'b0;
    logic        reset;
    logic        load_active;
    logic        write_en;
    logic [7:0]  write_index;
    logic [15:0] write_instruction;
    logic [7:0]  fetch_addr;
    logic        fetch_en;
    logic [15:0] fetch_data;
    logic        fetch_valid;
    logic        fetch_fault;
    logic        ready;
    logic [7:0]  loaded_count;
    logic [15:0] checksum;

    typedef struct {
        string       name;
        logic        valid;
        logic [15:0] data;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    logic issued = 1'b0;

    instruction_store dut (
        .clk               (clk),
        .reset             (reset),
        .load_active       (load_active),
        .write_en          (write_en),
        .write_index       (write_index),
        .write_instruction (write_instruction),
        .fetch_addr        (fetch_addr),
        .fetch_en          (fetch_en),
        .fetch_data        (fetch_data),
        .fetch_valid       (fetch_valid),
        .fetch_fault       (fetch_fault),
        .ready             (ready),
        .loaded_count      (loaded_count),
        .checksum          (checksum)
    );

    always #5 clk = ~clk;

    // Monitor: a fetch request seen at an edge owes exactly one response after it.
    always @(posedge clk) issued <= fetch_en;

    always @(negedge clk) begin
        if (issued) begin
            exp_t e;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_response: valid=%0b data=%h fault=%0b, required no pending fetch",
                         fetch_valid, fetch_data, fetch_fault);
            end else begin
                e = sb.pop_front();
                if (fetch_valid !== e.valid || fetch_data !== e.data || fetch_fault !== e.fault) begin
                    bad++;
                    $display("FAIL %s: valid=%0b data=%h fault=%0b, required valid=%0b data=%h fault=%0b",
                             e.name, fetch_valid, fetch_data, fetch_fault, e.valid, e.data, e.fault);
                end else begin
                    $display("fetch %s: valid=%0b data=%h fault=%0b", e.name, fetch_valid, fetch_data, fetch_fault);
                end
            end
        end else if (fetch_valid !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL spurious_valid: valid=%b, required 0", fetch_valid);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, actual, expected);
        end else begin
            $display("check %s: %h", name, actual);
        end
    endtask

    task automatic do_fetch(input string name, input logic [7:0] addr, input logic v,
                            input logic [15:0] d, input logic f);
        fetch_en   = 1'b1;
        fetch_addr = addr;
        sb.push_back('{name, v, d, f});
        step();
        fetch_en = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] idx, input logic [15:0] word);
        write_en          = 1'b1;
        write_index       = idx;
        write_instruction = word;
        step();
        write_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        load_active = 1'b0;
        write_en = 1'b0;
        write_index = '0;
        write_instruction = '0;
        fetch_addr = '0;
        fetch_en = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("reset_ready", {15'b0, ready}, 16'd0);
        check("reset_count", {8'b0, loaded_count}, 16'd0);
        check("reset_checksum", checksum, 16'h0000);
        check("reset_fetch_data", fetch_data, 16'h0000);
        do_fetch("fetch_when_empty", 8'd3, 1'b0, 16'h0000, 1'b0);

        // First program: four words at 10..13.
        load_active = 1'b1;
        step();
        do_write(8'd10, 16'h2021);
        do_write(8'd11, 16'h0022);
        do_write(8'd12, 16'h0023);
        do_write(8'd13, 16'h202b);
        load_active = 1'b0;
        step();
        check("load1_ready", {15'b0, ready}, 16'd1);
        check("load1_count", {8'b0, loaded_count}, 16'd4);
        check("load1_checksum", checksum, 16'h4091);
        do_fetch("fetch_12", 8'd12, 1'b1, 16'h0023, 1'b0);
        step();
        check("idle_holds_data", fetch_data, 16'h0023);
        do_fetch("fetch_200_unwritten", 8'd200, 1'b1, 16'hfee7, 1'b1);
        do_fetch("fetch_13", 8'd13, 1'b1, 16'h202b, 1'b0);
        do_fetch("fetch_10", 8'd10, 1'b1, 16'h2021, 1'b0);

        // Second program replaces the first; old slots become unwritten.
        load_active = 1'b1;
        step();
        do_write(8'd10, 16'h0000);
        load_active = 1'b0;
        step();
        check("load2_ready", {15'b0, ready}, 16'd1);
        check("load2_count", {8'b0, loaded_count}, 16'd1);
        check("load2_checksum", checksum, 16'h0000);
        do_fetch("load2_fetch_11", 8'd11, 1'b1, 16'hfee7, 1'b1);
        do_fetch("load2_fetch_10", 8'd10, 1'b1, 16'h0000, 1'b0);

        // Fetch in flight as a load starts is delivered; the next one is refused.
        fetch_en = 1'b1;
        fetch_addr = 8'd10;
        load_active = 1'b1;
        sb.push_back('{"inflight_at_load", 1'b1, 16'h0000, 1'b0});
        step();
        do_fetch("fetch_during_load", 8'd10, 1'b0, 16'h0000, 1'b0);
        check("loading_not_ready", {15'b0, ready}, 16'd0);
        load_active = 1'b0;
        step();
        check("empty_load_ready", {15'b0, ready}, 16'd0);
        do_fetch("fetch_after_empty_load", 8'd10, 1'b0, 16'h0000, 1'b0);

        // Repeated writes to one slot: last word kept, each counted, checksum wraps.
        load_active = 1'b1;
        step();
        do_write(8'd5, 16'h8000);
        do_write(8'd5, 16'h8000);
        do_write(8'd5, 16'h8001);
        load_active = 1'b0;
        step();
        check("repeat_count", {8'b0, loaded_count}, 16'd3);
        check("repeat_checksum", checksum, 16'h8001);
        do_fetch("repeat_fetch_5", 8'd5, 1'b1, 16'h8001, 1'b0);

        // Reset mid-load, with load_active and write_en still asserted.
        load_active = 1'b1;
        step();
        do_write(8'd1, 16'h1111);
        do_write(8'd2, 16'h2222);
        reset = 1'b1;
        write_en = 1'b1;
        write_index = 8'd3;
        write_instruction = 16'h3333;
        step();
        reset = 1'b0;
        write_en = 1'b0;
        load_active = 1'b0;
        check("abort_ready", {15'b0, ready}, 16'd0);
        check("abort_count", {8'b0, loaded_count}, 16'd0);
        check("abort_checksum", checksum, 16'h0000);
        do_fetch("abort_fetch_1", 8'd1, 1'b0, 16'h0000, 1'b0);

        // Written map was cleared by reset even though RAM still holds slot 1.
        load_active = 1'b1;
        step();
        do_write(8'd3, 16'h0abc);
        load_active = 1'b0;
        step();
        do_fetch("post_reset_fetch_1", 8'd1, 1'b1, 16'hfee7, 1'b1);
        do_fetch("post_reset_fetch_3", 8'd3, 1'b1, 16'h0abc, 1'b0);
        step();
        step();
        check("scoreboard_drained", 16'(sb.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
